sysid_probe_master: RTL
=======================

# sysid_probe_master

Avalon-MM master that interrogates the system-ID slave (word 0 = system ID, word 1 = build timestamp) and reports whether the hardware matches the expected build. It sits beside the Nios II on the system interconnect as a second master and gives boot firmware and board-level LEDs one pass/fail verdict, without any CPU cycles. It handles waitrequest stalls, a per-read timeout and a bounded number of retries.

## Interface
- EXPECTED_ID, 32'd0, system ID value required at word 0
- EXPECTED_TS, 32'h512C_17D7 (1361844183), build timestamp required at word 1
- TIMEOUT_CYCLES, 255, consecutive waitrequest-high cycles before a read is abandoned (1..65535)
- MAX_RETRIES, 3, extra attempts of the whole sequence after a timeout (0..15)
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a probe sequence
- address  out  1  word address to the slave: 0 = ID, 1 = timestamp
- read  out  1  Avalon read strobe
- readdata  in  32  slave read data
- waitrequest  in  1  slave stall
- busy  out  1  sequence in progress
- done  out  1  verdict valid; held until the next accepted start
- pass  out  1  ID and timestamp both matched; valid while done=1
- timeout_err  out  1  retries exhausted without completing both reads
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE: start=1 -> RD_ID. Clear done, pass, timeout_err, retry count and timeout counter.
- RD_ID: read=1, address=0. In the first cycle with waitrequest=0, capture readdata into id_value and go to RD_TS.
- RD_TS: read=1, address=1. In the first cycle with waitrequest=0, capture readdata into ts_value and go to CHECK.
- CHECK: pass <= (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS). Go to DONE.
- DONE: done=1. start=1 -> RD_ID with the same clearing as IDLE.
- Handshake: address and read stay stable while waitrequest=1. read is deasserted for exactly one cycle between accepted reads of the same attempt only when a timeout restarts the sequence. Back-to-back reads are otherwise allowed.
- Timeout: a 16-bit counter increments each cycle with read=1 and waitrequest=1, and clears on every accepted read.
  - Counter reaching TIMEOUT_CYCLES: drop read for one cycle and increment the retry count.
  - retry count <= MAX_RETRIES: restart at RD_ID.
  - Otherwise: go to DONE with timeout_err=1 and pass=0.
- start while busy=1 is ignored.
- The retry count saturates and never wraps.
- Captured values are retained in DONE and after a timeout. Only reset clears them.

## Timing
- Reset values: read=0, address=0, busy=0, done=0, pass=0, timeout_err=0, id_value=0, ts_value=0, state IDLE (see Configuration).
- Zero-wait slave, start sampled at edge N:
  - read=1, address=0 from edge N.
  - ID captured at edge N+1; address=1 from N+1.
  - timestamp captured at edge N+2.
  - CHECK at N+2..N+3; done=1 and pass valid from edge N+3.
- Each waitrequest-high cycle adds one cycle of latency.
- busy=1 exactly while in RD_ID, RD_TS or CHECK.
- Reset mid-transfer: read drops immediately (asynchronously). No partial result is reported.

## Configuration
- SYSID_PROBE_AUTOSTART_EN defined: after reset deasserts, the block behaves as if start=1 was sampled on the first clock edge, so a probe runs once per reset with no software involvement. Later start pulses rerun it.
- SYSID_PROBE_AUTOSTART_EN undefined: the block stays in IDLE until start is pulsed.

## Structure
- A shared package holds:
  - the state enum (IDLE, RD_ID, RD_TS, CHECK, DONE)
  - localparams ADDR_ID=1'b0, ADDR_TS=1'b1
  - the default EXPECTED_ID/EXPECTED_TS constants
- Sub-module sysid_probe_timeout holds the timeout counter and its terminal-count compare. It has enable, clear and expired ports.
- The FSM, capture registers and compare stay in the top module.

## Test plan
- Zero-wait slave returning 0 at word 0 and 1361844183 at word 1, then start -> two reads at addresses 0,1, done=1 at N+3, pass=1, timeout_err=0.
- Slave returning 0x0000_0001 at word 0 -> done=1, pass=0, id_value=1.
- waitrequest high for 10 cycles on each read -> address/read stable throughout, done at N+23, pass=1.
- waitrequest held high permanently, TIMEOUT_CYCLES=8, MAX_RETRIES=2 -> three attempts with a one-cycle read gap between them, then done=1, timeout_err=1, pass=0.
- Reset asserted during RD_TS stall -> read=0 immediately, all outputs at reset values; with SYSID_PROBE_AUTOSTART_EN the probe reruns and passes after reset release.
- start pulsed while busy, and start pulsed in DONE -> the first is ignored; the second clears done and reruns the sequence.

Source files
------------

// File: rtl/sysid_probe_master_pkg.sv
// Shared types and constants for the system-ID probe master.
package sysid_probe_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_t;

    // Word addresses inside the system-ID slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Build identity the hardware is expected to report
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h512C_17D7;

    // Stall counter width and retry counter width (wide enough that saturation
    // sits above any legal MAX_RETRIES)
    localparam int unsigned TIMEOUT_WIDTH = 16;
    localparam int unsigned RETRY_WIDTH   = 5;

endpackage

// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only bus between the probe master and the system-ID slave.
interface sysid_probe_master_if;

    logic        address;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address,
        output read,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        output waitrequest
    );

endinterface

// File: rtl/sysid_probe_timeout.sv
// Per-read stall timer: counts consecutive stalled read cycles and flags the
// cycle in which the TIMEOUT_CYCLES-th consecutive stall occurs.
module sysid_probe_timeout
    import sysid_probe_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [TIMEOUT_WIDTH-1:0] TERMINAL = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Stall counter; clear wins over counting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERMINAL);

endmodule

// File: rtl/sysid_probe_master.sv
// System-ID probe master: reads the ID and build timestamp words from the
// system-ID slave and reports a single pass/fail verdict.
// Optional feature macro: SYSID_PROBE_AUTOSTART_EN (run one probe per reset).
module sysid_probe_master
    import sysid_probe_master_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    sysid_probe_master_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);

    state_t                 state;
    logic                   read_q;
    logic                   addr_q;
    logic [RETRY_WIDTH-1:0] retry_cnt;
    logic [RETRY_WIDTH-1:0] retry_next;
    logic                   kick;
    logic                   launch;
    logic                   accept;
    logic                   expired;
    logic                   retry_left;

`ifdef SYSID_PROBE_AUTOSTART_EN
    logic auto_pend;

    // One-shot request standing in for a start pulse on the first edge after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign kick = start || auto_pend;
`else
    assign kick = start;
`endif

    assign bus.read    = read_q;
    assign bus.address = addr_q;

    assign launch     = kick && ((state == IDLE) || (state == DONE));
    assign accept     = read_q && !bus.waitrequest;
    assign retry_left = retry_cnt < RETRY_WIDTH'(MAX_RETRIES);
    assign retry_next = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;

    sysid_probe_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .enable  (read_q && bus.waitrequest),
        .clear   (launch || accept || expired),
        .expired (expired)
    );

    // Probe sequencer with registered bus strobes, status flags and captures.
    // A timeout leaves the FSM in RD_ID with read low; the RD_ID branch re-raises
    // read on the following edge, which produces the one-cycle gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            read_q      <= 1'b0;
            addr_q      <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            retry_cnt   <= '0;
        end else if (expired) begin
            read_q    <= 1'b0;
            addr_q    <= ADDR_ID;
            retry_cnt <= retry_next;
            if (retry_left) begin
                state <= RD_ID;
            end else begin
                state       <= DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                pass        <= 1'b0;
                timeout_err <= 1'b1;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (kick) begin
                        state       <= RD_ID;
                        read_q      <= 1'b1;
                        addr_q      <= ADDR_ID;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout_err <= 1'b0;
                        retry_cnt   <= '0;
                    end
                end
                RD_ID: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                        addr_q <= ADDR_ID;
                    end else if (accept) begin
                        id_value <= bus.readdata;
                        addr_q   <= ADDR_TS;
                        state    <= RD_TS;
                    end
                end
                RD_TS: begin
                    if (accept) begin
                        ts_value <= bus.readdata;
                        read_q   <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
